// File: rtl/pitch_pkg.sv
// Shared definitions for the pitch core and its SDRAM bridge.
package pitch_pkg;

   localparam int SDRAM_WORD_W = 32;
   localparam int PITCH_ADDR_W = 23;
   localparam int ORPHAN_W     = 4;

   localparam logic [3:0]          SDRAM_BYTEENABLE = 4'hF;
   localparam logic [ORPHAN_W-1:0] ORPHAN_MAX       = 4'd15;
   localparam logic [ORPHAN_W-1:0] ORPHAN_ONE       = 4'd1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_DATA,
      ST_RESP,
      ST_GAP
   } bridge_state_t;

   // Orphan read tracking: a timed-out read adds one (saturating), a stale
   // readdatavalid removes one; both in the same cycle cancel out.
   function automatic logic [ORPHAN_W-1:0] orphan_update(
      input logic [ORPHAN_W-1:0] cur,
      input logic                inc,
      input logic                dec
   );
      logic [ORPHAN_W-1:0] res;
      res = cur;
      if (inc && !dec) begin
         if (cur != ORPHAN_MAX) begin
            res = cur + ORPHAN_ONE;
         end
      end else if (dec && !inc) begin
         res = cur - ORPHAN_ONE;
      end
      return res;
   endfunction

endpackage

// File: rtl/pitch_sdram_timer.sv
// Up-counter with synchronous clear and a terminal-count flag; it stops
// counting once the terminal value is reached.
module pitch_sdram_timer #(
   parameter int TERMINAL = 1023
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic load,
   input  logic enable,
   output logic terminal_count
);

   // The counter holds 0..TERMINAL-1; the flag marks the TERMINAL-th cycle.
   localparam int CNT_W = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMINAL - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] count_reg;

   assign terminal_count = (count_reg == CNT_LAST);

   // Clear on load, otherwise advance while enabled until terminal.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= '0;
      end else if (enable && !terminal_count) begin
         count_reg <= count_reg + CNT_ONE;
      end
   end

endmodule

// File: rtl/pitch_sdram_bridge.sv
// Turns each level-held pitch-core request into one Avalon-MM transaction
// and answers with a single-cycle finished pulse (plus data on reads).
module pitch_sdram_bridge
   import pitch_pkg::*;
#(
   parameter int          AVM_ADDR_W     = 25,
   parameter int unsigned BASE_WORD      = 0,
   parameter int          TIMEOUT_CYCLES = 1023
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    pitch_read,
   input  logic                    pitch_write,
   input  logic [PITCH_ADDR_W-1:0] pitch_addr,
   input  logic [SDRAM_WORD_W-1:0] pitch_writedata,
   output logic [SDRAM_WORD_W-1:0] pitch_readdata,
   output logic                    pitch_sdram_finished,
   output logic                    pitch_error,
   output logic [AVM_ADDR_W-1:0]   avm_address,
   output logic [3:0]              avm_byteenable,
   output logic                    avm_read,
   output logic                    avm_write,
   output logic [SDRAM_WORD_W-1:0] avm_writedata,
   input  logic [SDRAM_WORD_W-1:0] avm_readdata,
   input  logic                    avm_readdatavalid,
   input  logic                    avm_waitrequest
);

   localparam logic [AVM_ADDR_W-1:0] BASE_ADDR = AVM_ADDR_W'(BASE_WORD);

   bridge_state_t state_reg, state_next;

   logic [AVM_ADDR_W-1:0]   avm_address_reg, avm_address_next;
   logic [SDRAM_WORD_W-1:0] avm_writedata_reg, avm_writedata_next;
   logic                    avm_read_reg, avm_read_next;
   logic                    avm_write_reg, avm_write_next;
   logic [3:0]              avm_byteenable_reg;
   logic [SDRAM_WORD_W-1:0] readdata_reg, readdata_next;
   logic                    finished_reg, finished_next;
   logic                    error_reg, error_next;
   logic                    err_pending_reg, err_pending_next;
   logic [ORPHAN_W-1:0]     orphan_reg, orphan_next;

   logic                    orphan_inc;
   logic                    orphan_dec;
   logic                    timer_load;
   logic                    timer_enable;
   logic                    timer_tc;
   logic [AVM_ADDR_W-1:0]   mapped_addr;

   // Region offset; the sum wraps silently at the Avalon address width.
   assign mapped_addr  = BASE_ADDR + AVM_ADDR_W'(pitch_addr);
   assign timer_enable = (state_reg == ST_ISSUE) || (state_reg == ST_WAIT_DATA);
   // Any stale data strobe pays off one outstanding orphan, in every state.
   assign orphan_dec   = avm_readdatavalid && (orphan_reg != '0);

   pitch_sdram_timer #(
      .TERMINAL (TIMEOUT_CYCLES)
   ) u_timer (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .load           (timer_load),
      .enable         (timer_enable),
      .terminal_count (timer_tc)
   );

   // Next-state and next-output logic for the single-outstanding bridge.
   always_comb begin
      state_next         = state_reg;
      avm_address_next   = avm_address_reg;
      avm_writedata_next = avm_writedata_reg;
      avm_read_next      = avm_read_reg;
      avm_write_next     = avm_write_reg;
      readdata_next      = readdata_reg;
      finished_next      = 1'b0;
      error_next         = 1'b0;
      err_pending_next   = err_pending_reg;
      orphan_inc         = 1'b0;
      timer_load         = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            // Write wins a tie; a still-held read is picked up after GAP.
            if (pitch_write) begin
               avm_address_next   = mapped_addr;
               avm_writedata_next = pitch_writedata;
               avm_write_next     = 1'b1;
               err_pending_next   = 1'b0;
               timer_load         = 1'b1;
               state_next         = ST_ISSUE;
            end else if (pitch_read) begin
               avm_address_next   = mapped_addr;
               avm_read_next      = 1'b1;
               err_pending_next   = 1'b0;
               timer_load         = 1'b1;
               state_next         = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (!avm_waitrequest) begin
               avm_read_next  = 1'b0;
               avm_write_next = 1'b0;
               if (avm_write_reg) begin
                  state_next = ST_RESP;
               end else if (timer_tc) begin
                  // Read went out on the last allowed cycle: its data is
                  // still coming and must be swallowed later.
                  err_pending_next = 1'b1;
                  orphan_inc       = 1'b1;
                  state_next       = ST_RESP;
               end else begin
                  state_next = ST_WAIT_DATA;
               end
            end else if (timer_tc) begin
               avm_read_next    = 1'b0;
               avm_write_next   = 1'b0;
               err_pending_next = 1'b1;
               state_next       = ST_RESP;
            end
         end

         ST_WAIT_DATA: begin
            if (avm_readdatavalid && (orphan_reg == '0)) begin
               readdata_next = avm_readdata;
               state_next    = ST_RESP;
            end else if (timer_tc) begin
               err_pending_next = 1'b1;
               orphan_inc       = 1'b1;
               state_next       = ST_RESP;
            end
         end

         ST_RESP: begin
            finished_next = 1'b1;
            error_next    = err_pending_reg;
            state_next    = ST_GAP;
         end

         ST_GAP: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase

      orphan_next = orphan_update(orphan_reg, orphan_inc, orphan_dec);
   end

   // State and registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_reg          <= ST_IDLE;
         avm_address_reg    <= '0;
         avm_writedata_reg  <= '0;
         avm_read_reg       <= 1'b0;
         avm_write_reg      <= 1'b0;
         avm_byteenable_reg <= SDRAM_BYTEENABLE;
         readdata_reg       <= '0;
         finished_reg       <= 1'b0;
         error_reg          <= 1'b0;
         err_pending_reg    <= 1'b0;
         orphan_reg         <= '0;
      end else begin
         state_reg          <= state_next;
         avm_address_reg    <= avm_address_next;
         avm_writedata_reg  <= avm_writedata_next;
         avm_read_reg       <= avm_read_next;
         avm_write_reg      <= avm_write_next;
         avm_byteenable_reg <= SDRAM_BYTEENABLE;
         readdata_reg       <= readdata_next;
         finished_reg       <= finished_next;
         error_reg          <= error_next;
         err_pending_reg    <= err_pending_next;
         orphan_reg         <= orphan_next;
      end
   end

   assign pitch_readdata       = readdata_reg;
   assign pitch_sdram_finished = finished_reg;
   assign pitch_error          = error_reg;
   assign avm_address          = avm_address_reg;
   assign avm_byteenable       = avm_byteenable_reg;
   assign avm_read             = avm_read_reg;
   assign avm_write            = avm_write_reg;
   assign avm_writedata        = avm_writedata_reg;

endmodule

// File: doc/pitch_sdram_bridge.md
Name: pitch_sdram_bridge

Overview:
- Responder end of the pitch-core SDRAM request interface (pitch_read / pitch_write / pitch_addr / pitch_writedata / pitch_readdata / pitch_sdram_finished).
- Converts each level-held core request into exactly one Avalon-MM transaction on the SDRAM controller slave.
- Returns a one-cycle pitch_sdram_finished pulse with data.
- Sits between the pitch core and the SDRAM controller, one per core.

Parameters:
AVM_ADDR_W, 25, Avalon word-address width of the SDRAM controller slave.
BASE_WORD, 0, word offset added to pitch_addr (region of SDRAM owned by pitch core).
TIMEOUT_CYCLES, 1023, max cycles waiting on waitrequest or readdatavalid before error completion.

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, synchronous, active-high
pitch_read  in  1  read request, level-held by core until finished
pitch_write  in  1  write request, level-held by core until finished
pitch_addr  in  23  word address
pitch_writedata  in  32  {left[15:0], right[15:0]}
pitch_readdata  out  32  read data, valid when pitch_sdram_finished=1 for a read
pitch_sdram_finished  out  1  one-cycle completion pulse
pitch_error  out  1  high with finished when the transaction timed out
avm_address  out  AVM_ADDR_W  word address
avm_byteenable  out  4  always 4'hF
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  32  Avalon write data
avm_readdata  in  32  Avalon read data
avm_readdatavalid  in  1  Avalon read data strobe
avm_waitrequest  in  1  Avalon stall

Behaviour:
- Interface fixed: one clock i_clk; reset i_rst is synchronous and active-high.
- All outputs are registered.
- Reset values: all outputs 0 except avm_byteenable=4'hF. State=IDLE, orphan count=0, timer=0.
- States: IDLE, ISSUE, WAIT_DATA, RESP, GAP.
- IDLE:
  - If pitch_write=1: latch addr/data, go to ISSUE with avm_write=1.
  - Else if pitch_read=1: latch addr, go to ISSUE with avm_read=1.
  - Write has priority when both are high; the read stays pending and is served next.
- Address mapping: avm_address = BASE_WORD + zero-extended latched pitch_addr, modulo 2^AVM_ADDR_W (wraps silently).
- Latching: address and data are captured at acceptance; later changes on core inputs have no effect on the in-flight transaction.
- ISSUE:
  - Hold avm_read/avm_write, address and data stable while avm_waitrequest=1.
  - On the first cycle with waitrequest=0, the command is accepted: deassert the strobe next cycle.
  - Write accepted → RESP. Read accepted → WAIT_DATA.
- WAIT_DATA:
  - On avm_readdatavalid: if orphan>0, decrement orphan and discard the data (stay in WAIT_DATA).
  - Otherwise register avm_readdata into pitch_readdata → RESP.
- RESP:
  - pitch_sdram_finished=1 for exactly one cycle.
  - pitch_readdata holds its value until the next read completes.
  - → GAP.
- GAP: one idle cycle, requests ignored, so the core can register its next addr/request. → IDLE.
- Minimum latency:
  - Write, from request seen in IDLE to finished pulse: 3 cycles.
  - Read with 0 waitrequest and readdatavalid k cycles after acceptance: 3+k cycles.
- Throughput: at most one transaction per 4+k cycles; no pipelining, single outstanding.
- Timeout:
  - A timer counts cycles spent in ISSUE+WAIT_DATA and clears on entry to ISSUE.
  - On reaching TIMEOUT_CYCLES: deassert strobes, go to RESP with pitch_error=1 (pitch_readdata unchanged).
  - If the read command was already accepted, increment orphan (saturating at 15) so its late readdatavalid is discarded.
  - pitch_error is a pulse aligned with finished.
- readdatavalid outside WAIT_DATA: if orphan>0, decrement orphan; otherwise ignore.
- Reset mid-operation:
  - Strobes drop on the next edge; orphan is cleared.
  - Any in-flight read data arriving afterwards is ignored (IDLE), or consumed as valid by a subsequent read only if it arrives in that read's WAIT_DATA. Callers must not issue reads within 16 cycles after reset (documented restriction).
- Request dropped by core before acceptance: the transaction still completes; finished is still pulsed.

Decomposition:
- Package pitch_pkg (shared with the core): state enum for this block, SDRAM_WORD_W=32, PITCH_ADDR_W=23, byteenable constant 4'hF.
- One natural sub-module: pitch_sdram_timer (loadable up-counter with terminal-count flag), used for the timeout.

Test Plan:
1. Write, addr=23'h000010, data=32'hAAAA5555, waitrequest=0 → one avm_write cycle at address 0x10 with that data; finished pulse 3 cycles after request; pitch_error=0.
2. Read, addr=23'h000004, readdatavalid 2 cycles after acceptance with 32'h12345678 → pitch_readdata=32'h12345678 with a 1-cycle finished pulse, 5 cycles after request.
3. Read with waitrequest held 6 cycles → avm_read, address stable for 7 cycles, exactly one acceptance, one finished pulse.
4. pitch_read and pitch_write both high → write executes first; read executes after GAP; two finished pulses, write first.
5. TIMEOUT_CYCLES=8, read accepted, no readdatavalid → finished with pitch_error=1 after timeout. Late valid 32'hDEAD0000 is discarded; the next read returns its own data 32'h0000BEEF.
6. Streaming: core increments pitch_addr on each finished for 512 reads from BASE_WORD=0x100 → avm_address sequence 0x100..0x2FF with no duplicates or skips; i_rst pulsed mid-stream → outputs return to reset values next edge.
